// File: rtl/ssp_pkg.sv
// Shared SSP constants and types: default FIFO geometry, pointer width and the data byte type.
package ssp_pkg;

    localparam int SSP_DATA_W = 8;
    localparam int SSP_DEPTH  = 4;
    localparam int PTR_W      = $clog2(SSP_DEPTH) + 1;

    typedef logic [SSP_DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
// Always accepts a write; the caller decides whether a write is allowed.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are never reset; the pointers alone decide what is valid.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_fifo.sv
// SSP receive FIFO, first-word fall-through: a byte pushed into an empty FIFO shows on prdata after one edge.
// Pushes while full are dropped unless a pop frees a slot that cycle; RXFIFO_OVERRUN_EN adds a sticky rxovr flag.
module rx_fifo
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_DEPTH
) (
    input  logic              pclk,
    input  logic              clear_b,
    input  logic              psel,
    input  logic              pwrite,
    input  logic              w_en,
    input  logic [DATA_W-1:0] rxdata,
    output logic              ssprxintr,
`ifdef RXFIFO_OVERRUN_EN
    output logic              rxovr,
`endif
    output logic [DATA_W-1:0] prdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              intr_q, intr_d;
    logic [DATA_W-1:0] rd_data;
    logic              empty, full, push, pop;

    // The MSB of each pointer is a wrap bit separating full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = psel && !pwrite && !empty;
    assign push  = w_en && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        intr_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    end

    always_ff @(posedge pclk or posedge clear_b) begin
        if (clear_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            intr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            intr_q   <= intr_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (pclk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (rxdata),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    assign prdata    = empty ? '0 : rd_data;
    assign ssprxintr = intr_q;

`ifdef RXFIFO_OVERRUN_EN
    logic ovr_q, ovr_d;

    assign ovr_d = ovr_q || (w_en && full && !pop);

    always_ff @(posedge pclk or posedge clear_b) begin
        if (clear_b) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign rxovr = ovr_q;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_rx_fifo;
    import ssp_pkg::*;

    localparam int DEPTH = 4;

    logic       pclk = 1'b0;
    logic       clear_b;
    logic       psel, pwrite, w_en;
    logic [7:0] rxdata;
    logic       ssprxintr;
    logic [7:0] prdata;
`ifdef RXFIFO_OVERRUN_EN
    logic       rxovr;
`endif

    int total = 0;
    int bad   = 0;

    data_t mq[$];
    bit    m_ovr;

    always #5 pclk = ~pclk;

    rx_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .pclk      (pclk),
        .clear_b   (clear_b),
        .psel      (psel),
        .pwrite    (pwrite),
        .w_en      (w_en),
        .rxdata    (rxdata),
        .ssprxintr (ssprxintr),
`ifdef RXFIFO_OVERRUN_EN
        .rxovr     (rxovr),
`endif
        .prdata    (prdata)
    );

    function automatic logic [7:0] exp_prdata();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    function automatic logic exp_intr();
        return mq.size() == DEPTH;
    endfunction

    // Drive one cycle from a negedge, update the model on the rising edge, return at the next negedge.
    task automatic step(input logic w, input logic [7:0] d, input logic s, input logic wr);
        bit do_pop, do_push;
        w_en = w; rxdata = d; psel = s; pwrite = wr;
        do_pop  = s && !wr && (mq.size() != 0);
        do_push = w && ((mq.size() < DEPTH) || do_pop);
        if (w && (mq.size() == DEPTH) && !do_pop) m_ovr = 1'b1;
        @(posedge pclk);
        if (do_pop) mq.delete(0);
        if (do_push) mq.push_back(d);
        @(negedge pclk);
        w_en = 1'b0; psel = 1'b0; pwrite = 1'b0;
    endtask

    task automatic do_reset();
        clear_b = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        clear_b = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
    endtask

    task automatic test_reset();
        clear_b = 1'b1; w_en = 0; psel = 0; pwrite = 0; rxdata = 8'h00;
        @(negedge pclk);
        @(negedge pclk);
        total++; if (prdata !== 8'h00) begin bad++; $display("FAIL reset_prdata got=%h exp=00", prdata); end
        total++; if (ssprxintr !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b exp=0", ssprxintr); end
`ifdef RXFIFO_OVERRUN_EN
        total++; if (rxovr !== 1'b0) begin bad++; $display("FAIL reset_rxovr got=%b exp=0", rxovr); end
`endif
        clear_b = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            total++; if (prdata !== 8'h00) begin bad++; $display("FAIL fill_prdata[%0d] got=%h exp=00", i, prdata); end
            total++; if (ssprxintr !== (i == 3)) begin bad++; $display("FAIL fill_intr[%0d] got=%b exp=%b", i, ssprxintr, (i == 3)); end
        end
    endtask

    task automatic test_overflow_drain();
        step(1'b1, 8'h04, 1'b0, 1'b0);
        total++; if (ssprxintr !== 1'b1) begin bad++; $display("FAIL ovf_intr got=%b exp=1", ssprxintr); end
`ifdef RXFIFO_OVERRUN_EN
        total++; if (rxovr !== 1'b1) begin bad++; $display("FAIL ovf_rxovr got=%b exp=1", rxovr); end
`endif
        for (int i = 0; i < 4; i++) begin
            total++; if (prdata !== 8'(i)) begin bad++; $display("FAIL drain_prdata[%0d] got=%h exp=%h", i, prdata, 8'(i)); end
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (ssprxintr !== 1'b0) begin bad++; $display("FAIL drain_intr[%0d] got=%b exp=0", i, ssprxintr); end
        end
        total++; if (prdata !== 8'h00) begin bad++; $display("FAIL drain_empty_prdata got=%h exp=00", prdata); end
`ifdef RXFIFO_OVERRUN_EN
        total++; if (rxovr !== 1'b1) begin bad++; $display("FAIL drain_rxovr_sticky got=%b exp=1", rxovr); end
`endif
    endtask

    task automatic test_empty_rules();
        step(1'b0, 8'h5A, 1'b1, 1'b1);
        total++; if (prdata !== 8'h00) begin bad++; $display("FAIL apbwr_prdata got=%h exp=00", prdata); end
        total++; if (ssprxintr !== 1'b0) begin bad++; $display("FAIL apbwr_intr got=%b exp=0", ssprxintr); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (prdata !== 8'h00) begin bad++; $display("FAIL pop_empty_prdata got=%h exp=00", prdata); end
        // Push and read together on an empty FIFO: only the push takes effect.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        total++; if (prdata !== 8'h77) begin bad++; $display("FAIL empty_pushpop_prdata got=%h exp=77", prdata); end
        step(1'b1, 8'h78, 1'b1, 1'b1);
        total++; if (prdata !== 8'h77) begin bad++; $display("FAIL apbwr_nopop_prdata got=%h exp=77", prdata); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (prdata !== 8'h78) begin bad++; $display("FAIL second_prdata got=%h exp=78", prdata); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (prdata !== 8'h00) begin bad++; $display("FAIL empty_again_prdata got=%h exp=00", prdata); end
    endtask

    task automatic test_full_simul();
        logic [7:0] expv [5];
        expv[0] = 8'hA1; expv[1] = 8'hA2; expv[2] = 8'hA3; expv[3] = 8'hAA; expv[4] = 8'h00;
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        total++; if (prdata !== 8'hA0) begin bad++; $display("FAIL simul_head got=%h exp=A0", prdata); end
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        total++; if (ssprxintr !== 1'b1) begin bad++; $display("FAIL simul_intr got=%b exp=1", ssprxintr); end
        for (int i = 0; i < 4; i++) begin
            total++; if (prdata !== expv[i]) begin bad++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, prdata, expv[i]); end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++; if (prdata !== expv[4]) begin bad++; $display("FAIL simul_empty got=%h exp=00", prdata); end
    endtask

    task automatic test_wrap();
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            total++; if (prdata !== 8'h10 + 8'(i)) begin bad++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, prdata, 8'h10 + 8'(i)); end
            if (i + 2 < 10) step(1'b1, 8'h10 + 8'(i + 2), 1'b1, 1'b0);
            else            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++; if (prdata !== 8'h00) begin bad++; $display("FAIL wrap_empty got=%h exp=00", prdata); end
    endtask

    task automatic test_async_clear();
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        total++; if (prdata !== 8'hC0) begin bad++; $display("FAIL preclear_prdata got=%h exp=C0", prdata); end
        #2 clear_b = 1'b1;
        #1;
        total++; if (prdata !== 8'h00) begin bad++; $display("FAIL clear_prdata got=%h exp=00", prdata); end
        total++; if (ssprxintr !== 1'b0) begin bad++; $display("FAIL clear_intr got=%b exp=0", ssprxintr); end
        clear_b = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        @(negedge pclk);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        total++; if (prdata !== 8'h55) begin bad++; $display("FAIL postclear_prdata got=%h exp=55", prdata); end
`ifdef RXFIFO_OVERRUN_EN
        total++; if (rxovr !== 1'b0) begin bad++; $display("FAIL postclear_rxovr got=%b exp=0", rxovr); end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            total++; if (prdata !== exp_prdata()) begin bad++; $display("FAIL rand_prdata[%0d] got=%h exp=%h", n, prdata, exp_prdata()); end
            total++; if (ssprxintr !== exp_intr()) begin bad++; $display("FAIL rand_intr[%0d] got=%b exp=%b", n, ssprxintr, exp_intr()); end
`ifdef RXFIFO_OVERRUN_EN
            total++; if (rxovr !== m_ovr) begin bad++; $display("FAIL rand_rxovr[%0d] got=%b exp=%b", n, rxovr, m_ovr); end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_empty_rules();
        test_full_simul();
        test_wrap();
        test_async_clear();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive FIFO of the synchronous serial port (SSP).
- Buffers bytes shifted in by the receive logic (rxdata, w_en) until the APB side reads them out on prdata.
- Raises ssprxintr when the FIFO is full so software drains it.
- Sits between the SSP receive shifter and the APB slave interface.

Parameters:
- DATA_W, 8, width of each FIFO entry and of rxdata/prdata.
- DEPTH, 4, number of entries; must be a power of two, minimum 2.

Ports:
- pclk  input  1  APB clock; all state updates on its rising edge.
- clear_b  input  1  asynchronous reset, active-high: 1 clears the FIFO immediately; 0 is normal operation. The name is kept for codebase consistency; polarity is active-high.
- psel  input  1  APB peripheral select for the receive data register.
- pwrite  input  1  APB direction: 1 = write, 0 = read.
- w_en  input  1  write strobe from the receive shifter; one byte per cycle when high.
- rxdata  input  DATA_W  received byte to push.
- ssprxintr  output  1  receive interrupt, high while the FIFO is full.
- prdata  output  DATA_W  APB read data: the oldest entry.

Behaviour:
- Storage: DEPTH x DATA_W array.
  - Read and write pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
- Reset (clear_b=1, asynchronous):
  - Both pointers go to 0, so the FIFO is empty.
  - ssprxintr=0, prdata=0x00.
  - Array contents need not be cleared.
  - Reset mid-operation discards all stored data; the first write after release lands in entry 0.
- Push: w_en=1 and (not full, or a pop in the same cycle).
  - Writes rxdata at the write pointer; the write pointer increments on that pclk edge.
- Pop: psel=1 and pwrite=0 and not empty.
  - The read pointer increments on that pclk edge.
  - Every cycle meeting this condition pops one entry; psel held high for N cycles pops up to N entries.
- prdata is first-word fall-through and combinational from state:
  - Equals the entry at the read pointer when not empty; 0x00 when empty.
  - Valid in the same cycle psel is sampled; changes to the next entry after the pop edge.
- psel=1 with pwrite=1: no effect on the FIFO (writes to this register are ignored).
- Push when full with no simultaneous pop: the byte is dropped; pointers are unchanged.
- Pop when empty: ignored, and prdata stays 0x00.
- Simultaneous push and pop:
  - Non-empty and non-full: both occur; the occupancy is unchanged.
  - Empty: only the push occurs, and prdata shows the new byte the next cycle.
  - Full: both occur; the new byte takes the freed slot.
- Pointers wrap modulo 2*DEPTH; data order is strictly first-in first-out across wrap-around.
- ssprxintr is registered state derived from pointers: 1 exactly when full. It deasserts the cycle after the first pop from full.
- Latency: a byte pushed on edge k is visible on prdata after edge k if the FIFO was empty.

Optional Feature:
- Macro RXFIFO_OVERRUN_EN.
- When defined:
  - Adds output port rxovr (1 bit), a sticky overrun flag.
  - rxovr is set on the pclk edge where w_en=1, the FIFO is full and no pop occurs.
  - rxovr is cleared only by clear_b; it resets to 0.
- When undefined: the port is absent and dropped bytes are silent.
- The core FIFO behaviour is identical in both builds.

Decomposition:
- Shared package ssp_pkg: DATA_W default, DEPTH default, pointer-width constant PTR_W = $clog2(DEPTH)+1, and a typedef for the data byte.
- One natural sub-module, fifo_mem: the DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port.
- Pointer, flag and APB decode logic stay in rx_fifo.

Test Plan:
1. Reset, then 4 pushes with clear_b=0 (rxdata 0x00, 0x01, 0x02, 0x03, w_en=1, psel=0) -> ssprxintr=1 after the 4th edge; prdata=0x00 throughout (head entry).
2. Full, then push 0x04 with no read -> byte dropped; four reads (psel=1, pwrite=0) give prdata 0x00, 0x01, 0x02, 0x03; ssprxintr=0 after the first pop; prdata=0x00 once empty. With RXFIFO_OVERRUN_EN, rxovr=1 and it stays 1.
3. Empty FIFO, psel=1, pwrite=1 with w_en=0 -> pointers unchanged, prdata=0x00, ssprxintr=0.
4. Full FIFO with simultaneous w_en=1 (0xAA) and read -> occupancy stays 4, ssprxintr stays 1; the draining sequence ends with 0xAA.
5. Wrap: push/pop 10 bytes 0x10..0x19 interleaved at occupancy 2 -> read order is exactly 0x10..0x19.
6. Assert clear_b=1 asynchronously between edges with 3 bytes stored -> prdata=0x00 and ssprxintr=0 immediately; after release, push 0x55 -> prdata=0x55.
